data_stack: RTL and testbench

Hardware operand stack for the 16-bit stack processor; sits directly downstream of the control/data-memory integration stage. Each cycle it consumes the 3-bit `stackOP` from control and the 16-bit `stackWriteData` selected by the stack-control mux, and updates the stack. It exposes the top two entries to the ALU and memory-address paths and flags overflow and underflow. Top and second entries are held in dedicated registers; deeper entries live in a register array.

---
 rtl/data_stack_if.sv | 28 ++
 rtl/data_stack.sv | 161 ++++++++++++++++
 tb/tb_data_stack.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_stack_if.sv
// Operand-stack port bundle: control drives op/data/clearErr, the stack returns its state.
interface data_stack_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;

  logic [2:0]       stackOP;
  logic [WIDTH-1:0] stackWriteData;
  logic             clearErr;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] second;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output stackOP, stackWriteData, clearErr,
    input  top, second, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  stackOP, stackWriteData, clearErr,
    output top, second, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/data_stack.sv
// Hardware operand stack: top/second in dedicated registers, deeper entries in a spill array.
// One op per cycle, results visible right after the sampling edge; sticky over/underflow flags.
module data_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input logic          CLK,
  input logic          reset,
  data_stack_if.slave  bus
);
  localparam int unsigned DW = $clog2(DEPTH) + 1;
  localparam int unsigned AN = DEPTH - 2;
  localparam int unsigned AW = $clog2(AN);

  typedef enum logic [2:0] {
    OpNop     = 3'b000,
    OpPush    = 3'b001,
    OpPop     = 3'b010,
    OpReplace = 3'b011,
    OpBinop   = 3'b100,
    OpDup     = 3'b101,
    OpSwap    = 3'b110,
    OpOver    = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] arr_q [AN];
  logic [WIDTH-1:0] arr_d [AN];
  logic             ovf_q, unf_q;
  logic             ovf_set, unf_set;
  logic             has1, has2, has3, is_full;
  logic             do_push, do_pull;
  logic [WIDTH-1:0] push_val;
  logic [DW-1:0]    push_pos, pull_pos;
  logic [AW-1:0]    push_idx, pull_idx;

  assign op = op_e'(bus.stackOP);

  assign has1    = (depth_q != '0);
  assign has2    = (depth_q >= DW'(2));
  assign has3    = (depth_q >= DW'(3));
  assign is_full = (depth_q == DW'(DEPTH));

  // Old second lands at new depth-3 on a push; the entry under second sits at depth-3.
  // Both are only used when the depth checks guarantee they are in range.
  assign push_pos = depth_q - DW'(2);
  assign pull_pos = depth_q - DW'(3);
  assign push_idx = push_pos[AW-1:0];
  assign pull_idx = pull_pos[AW-1:0];

  // Decode the op, validate depth, and form next-state values.
  always_comb begin
    top_d    = top_q;
    second_d = second_q;
    depth_d  = depth_q;
    arr_d    = arr_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    do_push  = 1'b0;
    do_pull  = 1'b0;
    push_val = bus.stackWriteData;

    case (op)
      OpPush: begin
        if (is_full) ovf_set = 1'b1;
        else         do_push = 1'b1;
      end
      OpPop: begin
        if (!has1) unf_set = 1'b1;
        else begin
          top_d   = second_q;
          do_pull = 1'b1;
        end
      end
      OpReplace: begin
        if (!has1) unf_set = 1'b1;
        else       top_d   = bus.stackWriteData;
      end
      OpBinop: begin
        if (!has2) unf_set = 1'b1;
        else begin
          top_d   = bus.stackWriteData;
          do_pull = 1'b1;
        end
      end
      OpDup: begin
        // Empty is checked first so DUP on an empty stack reports underflow.
        if (!has1)        unf_set = 1'b1;
        else if (is_full) ovf_set = 1'b1;
        else begin
          push_val = top_q;
          do_push  = 1'b1;
        end
      end
      OpSwap: begin
        if (!has2) unf_set = 1'b1;
        else begin
          top_d    = second_q;
          second_d = top_q;
        end
      end
      OpOver: begin
        if (!has2)        unf_set = 1'b1;
        else if (is_full) ovf_set = 1'b1;
        else begin
          push_val = second_q;
          do_push  = 1'b1;
        end
      end
      default: ;
    endcase

    if (do_push) begin
      if (has2) arr_d[push_idx] = second_q;
      second_d = top_q;
      top_d    = push_val;
      depth_d  = depth_q + DW'(1);
    end

    // Vacated slots are zeroed so anything below the valid depth reads 0.
    if (do_pull) begin
      if (has3) begin
        second_d        = arr_q[pull_idx];
        arr_d[pull_idx] = '0;
      end else begin
        second_d = '0;
      end
      depth_d = depth_q - DW'(1);
    end
  end

  // State registers; a rejected op only touches the sticky flags (set beats clear).
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      top_q    <= '0;
      second_q <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < int'(AN); i++) arr_q[i] <= '0;
    end else begin
      top_q    <= top_d;
      second_q <= second_d;
      depth_q  <= depth_d;
      arr_q    <= arr_d;
      ovf_q    <= ovf_set | (ovf_q & ~bus.clearErr);
      unf_q    <= unf_set | (unf_q & ~bus.clearErr);
    end
  end

  assign bus.top       = top_q;
  assign bus.second    = second_q;
  assign bus.depth     = depth_q;
  assign bus.empty     = (depth_q == '0);
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack with hand-computed expectations.
module tb_data_stack;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_REPL = 3'b011;
  localparam logic [2:0] OP_BIN  = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_OVER = 3'b111;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  data_stack_if #(.DEPTH(16), .WIDTH(16)) bus ();

  data_stack #(.DEPTH(16), .WIDTH(16)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one op across a rising edge and return 1 time unit after it.
  task automatic do_op(input logic [2:0] op, input logic [15:0] d, input logic clr);
    bus.stackOP        = op;
    bus.stackWriteData = d;
    bus.clearErr       = clr;
    @(posedge clk);
    #1;
    bus.stackOP        = OP_NOP;
    bus.stackWriteData = '0;
    bus.clearErr       = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.stackOP        = OP_NOP;
    bus.stackWriteData = '0;
    bus.clearErr       = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_eq("rst_depth", 32'(bus.depth), 0);
    check_eq("rst_top", 32'(bus.top), 0);
    check_eq("rst_second", 32'(bus.second), 0);
    check_eq("rst_empty", 32'(bus.empty), 1);
    check_eq("rst_full", 32'(bus.full), 0);
    check_eq("rst_flags", {30'd0, bus.overflow, bus.underflow}, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: basic push/pop
    do_op(OP_PUSH, 16'h0011, 1'b0);
    do_op(OP_PUSH, 16'h0022, 1'b0);
    do_op(OP_PUSH, 16'h0033, 1'b0);
    check_eq("t1_top", 32'(bus.top), 32'h33);
    check_eq("t1_second", 32'(bus.second), 32'h22);
    check_eq("t1_depth", 32'(bus.depth), 3);
    do_op(OP_POP, 16'h0, 1'b0);
    check_eq("t1_pop_top", 32'(bus.top), 32'h22);
    check_eq("t1_pop_second", 32'(bus.second), 32'h11);
    do_op(OP_POP, 16'h0, 1'b0);
    do_op(OP_POP, 16'h0, 1'b0);
    check_eq("t1_end_top", 32'(bus.top), 0);
    check_eq("t1_end_depth", 32'(bus.depth), 0);
    check_eq("t1_end_empty", 32'(bus.empty), 1);
    check_eq("t1_end_unf", 32'(bus.underflow), 0);

    // 2: fill, overflow, drain in LIFO order
    for (int i = 1; i <= 16; i++) do_op(OP_PUSH, 16'(i), 1'b0);
    check_eq("t2_full", 32'(bus.full), 1);
    check_eq("t2_top", 32'(bus.top), 16);
    check_eq("t2_second", 32'(bus.second), 15);
    do_op(OP_PUSH, 16'hFFFF, 1'b0);
    check_eq("t2_ovf_top", 32'(bus.top), 16);
    check_eq("t2_ovf_depth", 32'(bus.depth), 16);
    check_eq("t2_ovf_flag", 32'(bus.overflow), 1);
    for (int i = 16; i >= 1; i--) begin
      check_eq("t2_drain_top", 32'(bus.top), 32'(i));
      do_op(OP_POP, 16'h0, 1'b0);
    end
    check_eq("t2_drain_empty", 32'(bus.empty), 1);
    check_eq("t2_drain_second", 32'(bus.second), 0);
    check_eq("t2_drain_unf", 32'(bus.underflow), 0);
    do_op(OP_NOP, 16'h0, 1'b1);
    check_eq("t2_ovf_clr", 32'(bus.overflow), 0);

    // 3: BINOP, SWAP, OVER
    do_op(OP_PUSH, 16'd5, 1'b0);
    do_op(OP_PUSH, 16'd7, 1'b0);
    do_op(OP_BIN, 16'd12, 1'b0);
    check_eq("t3_bin_top", 32'(bus.top), 12);
    check_eq("t3_bin_depth", 32'(bus.depth), 1);
    check_eq("t3_bin_second", 32'(bus.second), 0);
    do_op(OP_PUSH, 16'd3, 1'b0);
    do_op(OP_SWAP, 16'h0, 1'b0);
    check_eq("t3_swap_top", 32'(bus.top), 12);
    check_eq("t3_swap_second", 32'(bus.second), 3);
    do_op(OP_OVER, 16'h0, 1'b0);
    check_eq("t3_over_top", 32'(bus.top), 3);
    check_eq("t3_over_second", 32'(bus.second), 12);
    check_eq("t3_over_depth", 32'(bus.depth), 3);
    do_op(OP_POP, 16'h0, 1'b0);
    check_eq("t3_pop_second", 32'(bus.second), 3);
    do_op(OP_POP, 16'h0, 1'b0);
    do_op(OP_POP, 16'h0, 1'b0);
    check_eq("t3_drained", 32'(bus.depth), 0);

    // 4: underflow and sticky flag clear
    do_op(OP_POP, 16'h0, 1'b0);
    check_eq("t4_pop_unf", 32'(bus.underflow), 1);
    check_eq("t4_pop_depth", 32'(bus.depth), 0);
    do_op(OP_PUSH, 16'd9, 1'b0);
    do_op(OP_SWAP, 16'h0, 1'b0);
    check_eq("t4_swap_top", 32'(bus.top), 9);
    check_eq("t4_swap_depth", 32'(bus.depth), 1);
    do_op(OP_BIN, 16'h0055, 1'b0);
    check_eq("t4_bin_top", 32'(bus.top), 9);
    check_eq("t4_bin_depth", 32'(bus.depth), 1);
    check_eq("t4_unf", 32'(bus.underflow), 1);
    do_op(OP_NOP, 16'h0, 1'b1);
    check_eq("t4_clr", 32'(bus.underflow), 0);
    do_op(OP_POP, 16'h0, 1'b0);
    do_op(OP_POP, 16'h0, 1'b1);
    check_eq("t4_set_wins", 32'(bus.underflow), 1);
    check_eq("t4_set_wins_depth", 32'(bus.depth), 0);
    do_op(OP_DUP, 16'h0, 1'b1);
    check_eq("t4_dup_empty_unf", 32'(bus.underflow), 1);
    check_eq("t4_dup_empty_ovf", 32'(bus.overflow), 0);
    do_op(OP_REPL, 16'h7777, 1'b0);
    check_eq("t4_repl_empty_top", 32'(bus.top), 0);

    // 5: asynchronous reset mid-stream (underflow is still set from above)
    for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 16'(i), 1'b0);
    check_eq("t5_pre_depth", 32'(bus.depth), 4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_depth", 32'(bus.depth), 0);
    check_eq("t5_rst_top", 32'(bus.top), 0);
    check_eq("t5_rst_flags", {30'd0, bus.overflow, bus.underflow}, 0);
    @(negedge clk) rst_n = 1'b1;
    do_op(OP_PUSH, 16'h00AA, 1'b0);
    check_eq("t5_push_top", 32'(bus.top), 32'hAA);
    check_eq("t5_push_depth", 32'(bus.depth), 1);
    check_eq("t5_push_second", 32'(bus.second), 0);
    do_op(OP_POP, 16'h0, 1'b0);

    // 6: REPLACE and DUP
    do_op(OP_PUSH, 16'h1234, 1'b0);
    do_op(OP_REPL, 16'hBEEF, 1'b0);
    check_eq("t6_repl_top", 32'(bus.top), 32'hBEEF);
    check_eq("t6_repl_depth", 32'(bus.depth), 1);
    do_op(OP_DUP, 16'h0, 1'b0);
    check_eq("t6_dup_top", 32'(bus.top), 32'hBEEF);
    check_eq("t6_dup_second", 32'(bus.second), 32'hBEEF);
    check_eq("t6_dup_depth", 32'(bus.depth), 2);
    check_eq("t6_flags", {30'd0, bus.overflow, bus.underflow}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
